// File: rtl/multiplier_datapath.sv
// multiplier_datapath: shift-and-add unsigned multiplier datapath.
// Holds multiplicand M, accumulator {C,A} and multiplier Q. An external
// sequencer drives load/add/shift, and a rising edge on done captures {A,Q}
// into a result register with a valid/ack handshake.
// Optional feature: define MULTIPLIER_DATAPATH_ERR_EN to build the sticky
// control-protocol error flag; otherwise err is tied low.

module multiplier_datapath #(
    parameter int n    = 4,
    parameter int logn = 2
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           load,
    input  logic           add,
    input  logic           shift,
    input  logic           done,
    input  logic [n-1:0]   multiplicand,
    input  logic [n-1:0]   multiplier,
    input  logic           result_ack,
    output logic           Q0,
    output logic [2*n-1:0] product,
    output logic [2*n-1:0] result,
    output logic           result_valid,
    output logic           err
);

    // Shift count at which the multiply is complete; the counter stops here.
    localparam logic [logn:0] cnt_max = (logn+1)'(n);

    logic [n-1:0]  m;
    logic [n-1:0]  a;
    logic          c;
    logic [n-1:0]  q;
    logic [logn:0] cnt;
    logic          done_d;
    logic          capture;

    assign Q0      = q[0];
    assign product = {a, q};
    assign capture = done & ~done_d;

    // Arithmetic core: load beats shift, and shift beats add, so each cycle
    // performs at most one operation on the operand registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            m   <= '0;
            a   <= '0;
            c   <= 1'b0;
            q   <= '0;
            cnt <= '0;
        end else if (load) begin
            m   <= multiplicand;
            q   <= multiplier;
            a   <= '0;
            c   <= 1'b0;
            cnt <= '0;
        end else if (shift) begin
            a   <= {c, a[n-1:1]};
            q   <= {a[0], q[n-1:1]};
            c   <= 1'b0;
            if (cnt != cnt_max) begin
                cnt <= cnt + 1'b1;
            end
        end else if (add) begin
            {c, a} <= {1'b0, a} + {1'b0, m};
        end
    end

    // Result capture on the rising edge of done; a capture in the same cycle
    // as an ack wins so a fresh product is never dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            done_d       <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            done_d <= done;
            if (capture) begin
                result       <= {a, q};
                result_valid <= 1'b1;
            end else if (result_ack && result_valid) begin
                result_valid <= 1'b0;
            end
        end
    end

`ifdef MULTIPLIER_DATAPATH_ERR_EN
    logic protocol_violation;

    // Flags illegal control combinations: overlapping strobes, or stepping
    // past the final shift of an operation.
    always_comb begin
        protocol_violation = 1'b0;
        if (add && shift) begin
            protocol_violation = 1'b1;
        end
        if (load && (add || shift)) begin
            protocol_violation = 1'b1;
        end
        if ((shift || add) && (cnt == cnt_max)) begin
            protocol_violation = 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            err <= 1'b0;
        end else if (protocol_violation) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_multiplier_datapath.sv
// tb_multiplier_datapath: directed-vector bench for multiplier_datapath
// (n=4). Expected products are hand-computed constants; the error flag is
// expected high only when MULTIPLIER_DATAPATH_ERR_EN is defined.

module tb_multiplier_datapath;

    localparam int n  = 4;
    localparam int logn = 2;
    localparam int pw = 2 * n;

`ifdef MULTIPLIER_DATAPATH_ERR_EN
    localparam logic errOn = 1'b1;
`else
    localparam logic errOn = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset;
    logic           load;
    logic           add;
    logic           shift;
    logic           done;
    logic           resultAck;
    logic [n-1:0]   multiplicand;
    logic [n-1:0]   multiplier;
    logic           Q0;
    logic [pw-1:0]  product;
    logic [pw-1:0]  result;
    logic           resultValid;
    logic           err;

    int checks   = 0;
    int failures = 0;

    multiplier_datapath #(.n(n), .logn(logn)) dut (
        .clock        (clock),
        .reset        (reset),
        .load         (load),
        .add          (add),
        .shift        (shift),
        .done         (done),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .result_ack   (resultAck),
        .Q0           (Q0),
        .product      (product),
        .result       (result),
        .result_valid (resultValid),
        .err          (err)
    );

    // Free-running 10 ns clock.
    always #5 clock = ~clock;

    // Counts one comparison and reports it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [pw-1:0] actual,
                               input logic [pw-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one cycle of control inputs, then waits until just after the edge.
    task automatic applyStimulus(input logic rst, input logic ld, input logic ad,
                                 input logic sh, input logic dn, input logic ack);
        reset     = rst;
        load      = ld;
        add       = ad;
        shift     = sh;
        done      = dn;
        resultAck = ack;
        @(posedge clock);
        #1;
    endtask

    // Loads operands and runs n (add-if-bit, shift) pairs, checking Q0 each
    // step against the multiplier bit and the final product against a constant.
    task automatic runMultiply(input logic [n-1:0] mVal, input logic [n-1:0] qVal,
                               input logic [pw-1:0] expProduct, input string tag);
        multiplicand = mVal;
        multiplier   = qVal;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_q0_%0d", tag, i), pw'(Q0), pw'(qVal[i]));
            if (qVal[i]) begin
                applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            end
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        checkOutput({tag, "_product"}, product, expProduct);
    endtask

    initial begin
        multiplicand = '0;
        multiplier   = '0;
        $display("[TB] start");

        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_product", product, 8'h00);
        checkOutput("rst_result", result, 8'h00);
        checkOutput("rst_valid", pw'(resultValid), 8'h00);
        checkOutput("rst_err", pw'(err), 8'h00);
        checkOutput("rst_q0", pw'(Q0), 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 13 * 11 = 143, capture then ack
        runMultiply(4'd13, 4'd11, 8'h8F, "m13x11");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("m13x11_result", result, 8'd143);
        checkOutput("m13x11_valid", pw'(resultValid), 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("m13x11_ack_valid", pw'(resultValid), 8'd0);
        checkOutput("m13x11_ack_result", result, 8'd143);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 15 * 15 = 225 with done held 10 cycles and ack every cycle
        runMultiply(4'd15, 4'd15, 8'hE1, "m15x15");
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            if (k == 0) begin
                checkOutput("hold_first_valid", pw'(resultValid), 8'd1);
                checkOutput("hold_first_result", result, 8'd225);
            end else if (k == 1 || k == 9) begin
                checkOutput($sformatf("hold_valid_%0d", k), pw'(resultValid), 8'd0);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("hold_after_valid", pw'(resultValid), 8'd0);

        // Result survives a later operation; capture coincident with ack
        runMultiply(4'd13, 4'd11, 8'd143, "m13x11b");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runMultiply(4'd0, 4'd9, 8'd0, "m0x9");
        checkOutput("keep_result", result, 8'd143);
        checkOutput("keep_valid", pw'(resultValid), 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("coinc_result", result, 8'd0);
        checkOutput("coinc_valid", pw'(resultValid), 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Overwrite while valid without ack
        runMultiply(4'd15, 4'd15, 8'd225, "m15x15b");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("over_result", result, 8'd225);
        checkOutput("over_valid", pw'(resultValid), 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Activity then reset clears everything
        multiplicand = 4'd9;
        multiplier   = 4'd6;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst2_product", product, 8'd0);
        checkOutput("rst2_result", result, 8'd0);
        checkOutput("rst2_valid", pw'(resultValid), 8'd0);
        checkOutput("rst2_err", pw'(err), 8'd0);
        checkOutput("rst2_q0", pw'(Q0), 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during 2nd shift of 13*11 (done rising too), then 6*7
        multiplicand = 4'd13;
        multiplier   = 4'd11;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("abort_product", product, 8'd0);
        checkOutput("abort_valid", pw'(resultValid), 8'd0);
        checkOutput("abort_result", result, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runMultiply(4'd6, 4'd7, 8'd42, "m6x7");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("m6x7_result", result, 8'd42);
        checkOutput("m6x7_valid", pw'(resultValid), 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // add & shift together: shift only, error flag when enabled
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        multiplicand = 4'd3;
        multiplier   = 4'd5;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("err_clean", pw'(err), 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("addshift_product", product, 8'h02);
        checkOutput("addshift_err", pw'(err), pw'(errOn));
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("err_sticky", pw'(err), pw'(errOn));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("err_cleared", pw'(err), 8'd0);

        // Fifth shift past n raises error when enabled
        multiplicand = 4'd1;
        multiplier   = 4'd8;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("shift4_err", pw'(err), 8'd0);
        checkOutput("shift4_product", product, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("shift5_err", pw'(err), pw'(errOn));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
